// File: rtl/mem_hs_pkg.sv
// Shared types, default parameters and helpers for the multi-channel memory
// handshake arbiter (mem_hs_arb_ctl and its round-robin arbiter).
package mem_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_DW          = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 255;

    // A single channel still needs a one-bit index port.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/mem_hs_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, returning a one-hot grant, its index and a valid flag.
module mem_hs_rr_arb
    import mem_hs_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int IW   = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int              cand;
    logic [N_CH-1:0] req_sh;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        req_sh  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            req_sh = req_i >> cand;
            if (!valid_o && req_sh[0]) begin
                valid_o = 1'b1;
                gnt_o   = N_CH'(1) << cand;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_hs_arb_ctl.sv
// Round-robin arbiter of N_CH 4-phase client channels onto one 4-phase memory port.
// Optional memory-ack timeout enabled by defining MEM_HS_TIMEOUT_EN.
module mem_hs_arb_ctl
    import mem_hs_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int DW          = DEF_DW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_CH-1:0]           ch_req_i,
    input  logic [N_CH*DW-1:0]        ch_data_i,
    output logic [N_CH-1:0]           ch_ack_o,
    output logic                      mem_req_o,
    input  logic                      mem_ack_i,
    output logic [DW-1:0]             mem_data_o,
    output logic [ch_idx_w(N_CH)-1:0] mem_ch_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IW = ch_idx_w(N_CH);

    if (N_CH < 1 || DW < 1 || SYNC_STAGES < 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mem_hs_arb_ctl: illegal parameter value");
    end

    logic ack_s;

    // mem_ack_i may come from another clock domain, so it is resynchronised.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;

        always_comb begin
            sync_d = SYNC_STAGES'({sync_q, mem_ack_i});
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign ack_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign ack_s = mem_ack_i;
    end

    state_e          state_q,    state_d;
    logic            mem_req_q,  mem_req_d;
    logic [N_CH-1:0] ch_ack_q,   ch_ack_d;
    logic [N_CH-1:0] gnt_q,      gnt_d;
    logic [DW-1:0]   mem_data_q, mem_data_d;
    logic [IW-1:0]   mem_ch_q,   mem_ch_d;
    logic [IW-1:0]   ptr_q,      ptr_d;
    logic            busy_q,     busy_d;

    logic [N_CH-1:0]    arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic [N_CH*DW-1:0] data_sh;
    logic               grant_ok;

    mem_hs_rr_arb #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_arb (
        .req_i   (ch_req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign data_sh = ch_data_i >> (int'(arb_idx) * DW);

`ifdef MEM_HS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          tmo_hit;

    assign tmo_hit = (cnt_q == TW'(TIMEOUT_CYC - 1));
    // After a timeout the memory may still be acking; wait for it to let go.
    assign grant_ok = !ack_s;
`else
    assign grant_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        ch_ack_d   = ch_ack_q;
        gnt_d      = gnt_q;
        mem_data_d = mem_data_q;
        mem_ch_d   = mem_ch_q;
        ptr_d      = ptr_q;
`ifdef MEM_HS_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid && grant_ok) begin
                    gnt_d      = arb_gnt;
                    mem_data_d = data_sh[DW-1:0];
                    mem_ch_d   = arb_idx;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
`ifdef MEM_HS_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            REQ: begin
`ifdef MEM_HS_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    state_d   = REL;
                end
`ifdef MEM_HS_TIMEOUT_EN
                else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    ch_ack_d  = gnt_q;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            REL: begin
`ifdef MEM_HS_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!ack_s) begin
                    ch_ack_d = gnt_q;
                    state_d  = DONE;
                end
`ifdef MEM_HS_TIMEOUT_EN
                else if (tmo_hit) begin
                    ch_ack_d  = gnt_q;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                // A client that withdrew early leaves DONE on the very next cycle.
                if ((ch_req_i & gnt_q) == '0) begin
                    ch_ack_d = '0;
                    ptr_d    = (mem_ch_q == IW'(N_CH - 1)) ? '0 : mem_ch_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            ch_ack_q   <= '0;
            gnt_q      <= '0;
            mem_data_q <= '0;
            mem_ch_q   <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
`ifdef MEM_HS_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            ch_ack_q   <= ch_ack_d;
            gnt_q      <= gnt_d;
            mem_data_q <= mem_data_d;
            mem_ch_q   <= mem_ch_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
`ifdef MEM_HS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign ch_ack_o   = ch_ack_q;
    assign mem_req_o  = mem_req_q;
    assign mem_data_o = mem_data_q;
    assign mem_ch_o   = mem_ch_q;
    assign busy_o     = busy_q;
`ifdef MEM_HS_TIMEOUT_EN
    assign timeout_o  = timeout_q;
`else
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_hs_arb_ctl.sv
// Directed bench for mem_hs_arb_ctl: expected grants are queued as stimulus is
// issued and a monitor checks them as the memory request rises (MEM_HS_TIMEOUT_EN optional).
`timescale 1ns/1ps
module tb_mem_hs_arb_ctl;

    localparam int N_CH = 4;
    localparam int DW   = 32;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [N_CH-1:0]    ch_req_i;
    logic [N_CH*DW-1:0] ch_data_i;
    logic [N_CH-1:0]    ch_ack_o;
    logic               mem_req_o;
    logic               mem_ack_i;
    logic [DW-1:0]      mem_data_o;
    logic [1:0]         mem_ch_o;
    logic               busy_o;
    logic               timeout_o;

    int              n_checks = 0;
    int              n_fails  = 0;
    exp_t            exp_q[$];
    bit              mem_auto;
    logic [N_CH-1:0] client_auto;
    int              reqs_left[N_CH];

    mem_hs_arb_ctl #(
        .N_CH        (N_CH),
        .DW          (DW),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ch_req_i   (ch_req_i),
        .ch_data_i  (ch_data_i),
        .ch_ack_o   (ch_ack_o),
        .mem_req_o  (mem_req_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_o (mem_data_o),
        .mem_ch_o   (mem_ch_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a channel's payload and queue the grant it should eventually produce.
    task automatic applyStimulus(input int ch, input logic [31:0] data, input bit raise_now);
        exp_t e;
        ch_data_i[ch*DW +: DW] = data;
        e.ch   = ch;
        e.data = data;
        exp_q.push_back(e);
        if (raise_now) begin
            ch_req_i[ch] = 1'b1;
        end
    endtask

    // One cycle of the responsive memory and client models.
    task automatic tick_auto();
        step();
        if (mem_auto) begin
            if (mem_req_o && !mem_ack_i) begin
                mem_ack_i = 1'b1;
            end else if (!mem_req_o && mem_ack_i) begin
                mem_ack_i = 1'b0;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (client_auto[k]) begin
                if (ch_req_i[k] && ch_ack_o[k]) begin
                    ch_req_i[k] = 1'b0;
                end else if (!ch_req_i[k] && !ch_ack_o[k] && reqs_left[k] > 0) begin
                    ch_req_i[k] = 1'b1;
                    reqs_left[k]--;
                end
            end
        end
    endtask

    function automatic bit all_done();
        bit d;
        d = (ch_req_i == '0) && !busy_o && !mem_ack_i;
        for (int k = 0; k < N_CH; k++) begin
            if (reqs_left[k] != 0) begin
                d = 1'b0;
            end
        end
        return d;
    endfunction

    task automatic run_auto(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick_auto();
            n++;
        end while (!all_done() && n < budget);
        checkOutput({name, " completes"}, 32'(all_done()), 32'd1);
    endtask

    task automatic wait_mem_req(input logic lvl, input string name);
        for (int i = 0; i < 20 && mem_req_o !== lvl; i++) begin
            step();
        end
        checkOutput(name, 32'(mem_req_o), 32'(lvl));
    endtask

    // Monitor: pops an expected grant whenever mem_req_o rises.
    initial begin
        exp_t            cur;
        logic            prev_req;
        logic [N_CH-1:0] prev_ack;
        logic [N_CH-1:0] oh;
        cur.ch   = 0;
        cur.data = '0;
        prev_req = 1'b0;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (rst_ni !== 1'b1) begin
                prev_req = 1'b0;
                prev_ack = '0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected grant", 32'(mem_ch_o), 32'hFFFF_FFFF);
                    end else begin
                        cur = exp_q.pop_front();
                        checkOutput("grant channel", 32'(mem_ch_o), 32'(cur.ch));
                        checkOutput("grant data", mem_data_o, cur.data);
                    end
                end else if (mem_req_o && prev_req) begin
                    checkOutput("data stable", mem_data_o, cur.data);
                end
                checkOutput("ack one-hot", 32'($countones(ch_ack_o) <= 1), 32'd1);
                if (ch_ack_o != '0 && prev_ack == '0) begin
                    oh = '0;
                    oh[cur.ch] = 1'b1;
                    checkOutput("ack channel", 32'(ch_ack_o), 32'(oh));
                end
                prev_req = mem_req_o;
                prev_ack = ch_ack_o;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        ch_req_i    = '0;
        ch_data_i   = '0;
        mem_ack_i   = 1'b0;
        mem_auto    = 1'b0;
        client_auto = '0;
        for (int k = 0; k < N_CH; k++) reqs_left[k] = 0;
        repeat (3) step();
        checkOutput("reset mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("reset ch_ack", 32'(ch_ack_o), 32'd0);
        checkOutput("reset mem_data", mem_data_o, 32'd0);
        checkOutput("reset mem_ch", 32'(mem_ch_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset timeout", 32'(timeout_o), 32'd0);
        rst_ni = 1'b1;

        $display("[TB] round-robin with four continuous requesters");
        for (int k = 0; k < N_CH; k++) applyStimulus(k, 32'h10 + 32'(k), 1'b0);
        applyStimulus(0, 32'h10, 1'b0);
        reqs_left   = '{2, 1, 1, 1};
        mem_auto    = 1'b1;
        client_auto = '1;
        run_auto("rr four channels", 400);

        $display("[TB] single channel with asynchronous memory ack");
        mem_auto    = 1'b0;
        client_auto = '0;
        applyStimulus(0, 32'hDEADBEEF, 1'b1);
        step();
        checkOutput("single mem_req rises", 32'(mem_req_o), 32'd1);
        checkOutput("single mem_ch", 32'(mem_ch_o), 32'd0);
        checkOutput("single busy", 32'(busy_o), 32'd1);
        #3 mem_ack_i = 1'b1;
        step();
        checkOutput("sync req held 1", 32'(mem_req_o), 32'd1);
        step();
        checkOutput("sync req held 2", 32'(mem_req_o), 32'd1);
        step();
        checkOutput("sync REQ to REL", 32'(mem_req_o), 32'd0);
        checkOutput("single data held", mem_data_o, 32'hDEADBEEF);
        mem_ack_i = 1'b0;
        step();
        step();
        checkOutput("single ack waits release", 32'(ch_ack_o), 32'd0);
        step();
        checkOutput("single ack after release", 32'(ch_ack_o), 32'b0001);
        step();
        checkOutput("single ack held", 32'(ch_ack_o), 32'b0001);
        ch_req_i[0] = 1'b0;
        step();
        checkOutput("single ack clears", 32'(ch_ack_o), 32'd0);
        checkOutput("single busy clears", 32'(busy_o), 32'd0);

        $display("[TB] channel 2 transaction moves pointer to 3");
        applyStimulus(2, 32'h22, 1'b0);
        reqs_left[2] = 1;
        client_auto  = 4'b0100;
        mem_auto     = 1'b1;
        run_auto("ch2 transaction", 100);

        $display("[TB] reset pulse during REQ");
        mem_auto    = 1'b0;
        client_auto = '0;
        applyStimulus(3, 32'h33, 1'b1);
        wait_mem_req(1'b1, "reset test grant");
        step();
        rst_ni = 1'b0;
        step();
        checkOutput("mid reset mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("mid reset ch_ack", 32'(ch_ack_o), 32'd0);
        checkOutput("mid reset busy", 32'(busy_o), 32'd0);
        checkOutput("mid reset mem_data", mem_data_o, 32'd0);
        applyStimulus(2, 32'h22, 1'b1);
        applyStimulus(3, 32'h33, 1'b0);
        rst_ni = 1'b1;
        step();
        checkOutput("post reset grants ch2", 32'(mem_ch_o), 32'd2);
        client_auto = 4'b1100;
        mem_auto    = 1'b1;
        run_auto("post reset drain", 100);

        $display("[TB] request withdrawn during REQ");
        mem_auto    = 1'b0;
        client_auto = '0;
        applyStimulus(1, 32'hA5A5_0001, 1'b1);
        wait_mem_req(1'b1, "violation grant");
        ch_req_i[1] = 1'b0;
        step();
        step();
        checkOutput("violation still requesting", 32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1;
        wait_mem_req(1'b0, "violation REQ to REL");
        mem_ack_i = 1'b0;
        for (int i = 0; i < 20 && ch_ack_o == '0; i++) step();
        checkOutput("violation ack pulse", 32'(ch_ack_o), 32'b0010);
        step();
        checkOutput("violation ack one cycle", 32'(ch_ack_o), 32'd0);
        checkOutput("violation back to idle", 32'(busy_o), 32'd0);

`ifdef MEM_HS_TIMEOUT_EN
        $display("[TB] memory never acknowledges");
        applyStimulus(0, 32'h55, 1'b1);
        wait_mem_req(1'b1, "timeout grant");
        repeat (7) step();
        checkOutput("timeout not early", 32'(timeout_o), 32'd0);
        step();
        checkOutput("timeout flag", 32'(timeout_o), 32'd1);
        checkOutput("timeout drops mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("timeout acks client", 32'(ch_ack_o), 32'b0001);
        ch_req_i[0] = 1'b0;
        repeat (3) step();
        checkOutput("timeout sticky", 32'(timeout_o), 32'd1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        checkOutput("timeout cleared by reset", 32'(timeout_o), 32'd0);
`else
        checkOutput("timeout tied low", 32'(timeout_o), 32'd0);
`endif

        repeat (3) step();
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
